pwm_fade_ctrl: RTL and testbench

//  Sequencer for the 10-slot LED PWM: ramps the duty level up to a target, holds, ramps down, optionally loops ("breathing").

---
 rtl/pwm_fade_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_fade_ctrl
// Brief    : LED PWM breathing sequencer (prescaler, slot counter, duty FSM)
// Revision : 1.0
// ============================================================================
module pwm_fade_ctrl #(
    parameter int unsigned CLK_DIV     = 26999,
    parameter int unsigned PWM_TOP     = 9,
    parameter int unsigned STEP_FRAMES = 10,
    parameter int unsigned HOLD_FRAMES = 50,
    parameter logic        LED_ON      = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    input  logic [3:0] max_duty,
    output logic       led,
    output logic [3:0] duty,
    output logic       busy,
    output logic       frame_tc,
    output logic [2:0] state
);

    localparam int unsigned c_div_w   = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
    localparam int unsigned c_frm_max = (STEP_FRAMES > HOLD_FRAMES) ? STEP_FRAMES : HOLD_FRAMES;
    localparam int unsigned c_frm_w   = (c_frm_max > 1) ? $clog2(c_frm_max) : 1;

    localparam logic [c_div_w-1:0] c_div_top  = c_div_w'(CLK_DIV);
    localparam logic [3:0]         c_pwm_top  = 4'(PWM_TOP);
    localparam logic [3:0]         c_duty_max = 4'(PWM_TOP + 1);
    localparam logic [c_frm_w-1:0] c_step_last = c_frm_w'(STEP_FRAMES - 1);
    localparam logic [c_frm_w-1:0] c_hold_last = c_frm_w'(HOLD_FRAMES - 1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_up      = 3'd1;
    localparam logic [2:0] c_st_hold_hi = 3'd2;
    localparam logic [2:0] c_st_down    = 3'd3;
    localparam logic [2:0] c_st_hold_lo = 3'd4;

    logic [c_div_w-1:0] r_div;
    logic [3:0]         r_slot;
    logic [c_frm_w-1:0] r_frm;
    logic [2:0]         r_state;
    logic [3:0]         r_duty;
    logic [3:0]         r_target;
    logic               r_stop_req;
    logic               r_led;

    logic               w_tick;
    logic               w_frame_tc;
    logic [3:0]         w_clamp;
    logic [3:0]         w_duty_inc;

    assign w_tick     = (r_div == c_div_top);
    assign w_frame_tc = w_tick && (r_slot == c_pwm_top);
    assign w_clamp    = (max_duty > c_duty_max) ? c_duty_max : max_duty;
    assign w_duty_inc = r_duty + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div      <= '0;
            r_slot     <= '0;
            r_frm      <= '0;
            r_state    <= c_st_idle;
            r_duty     <= '0;
            r_target   <= '0;
            r_stop_req <= 1'b0;
            r_led      <= ~LED_ON;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_slot <= (r_slot == c_pwm_top) ? '0 : r_slot + 4'd1;
            end
            r_led <= (r_slot < r_duty) ? LED_ON : ~LED_ON;

            // Set first so that any IDLE entry below clears it in the same cycle.
            if (stop && (r_state != c_st_idle)) begin
                r_stop_req <= 1'b1;
            end

            case (r_state)
                c_st_idle: begin
                    if (start && !stop && (w_clamp != 4'd0)) begin
                        r_state  <= c_st_up;
                        r_target <= w_clamp;
                        r_frm    <= '0;
                    end
                end
                c_st_up: begin
                    if (w_frame_tc) begin
                        if (r_stop_req) begin
                            r_frm <= '0;
                            // Nothing to ramp down from: finish right away.
                            if (r_duty == 4'd0) begin
                                r_state    <= c_st_idle;
                                r_stop_req <= 1'b0;
                            end else begin
                                r_state <= c_st_down;
                            end
                        end else if (r_frm == c_step_last) begin
                            r_frm  <= '0;
                            r_duty <= w_duty_inc;
                            if (w_duty_inc == r_target) begin
                                r_state <= c_st_hold_hi;
                            end
                        end else begin
                            r_frm <= r_frm + 1'b1;
                        end
                    end
                end
                c_st_hold_hi: begin
                    if (w_frame_tc) begin
                        if (r_stop_req || (r_frm == c_hold_last)) begin
                            r_state <= c_st_down;
                            r_frm   <= '0;
                        end else begin
                            r_frm <= r_frm + 1'b1;
                        end
                    end
                end
                c_st_down: begin
                    if (w_frame_tc) begin
                        if (r_frm == c_step_last) begin
                            r_frm <= '0;
                            if (r_duty <= 4'd1) begin
                                r_duty <= 4'd0;
                                if (loop && !r_stop_req) begin
                                    r_state <= c_st_hold_lo;
                                end else begin
                                    r_state    <= c_st_idle;
                                    r_stop_req <= 1'b0;
                                end
                            end else begin
                                r_duty <= r_duty - 4'd1;
                            end
                        end else begin
                            r_frm <= r_frm + 1'b1;
                        end
                    end
                end
                c_st_hold_lo: begin
                    if (w_frame_tc) begin
                        if (r_stop_req) begin
                            r_state    <= c_st_idle;
                            r_stop_req <= 1'b0;
                            r_frm      <= '0;
                        end else if (r_frm == c_hold_last) begin
                            r_frm <= '0;
                            if (loop && (w_clamp != 4'd0)) begin
                                r_state  <= c_st_up;
                                r_target <= w_clamp;
                            end else begin
                                r_state    <= c_st_idle;
                                r_stop_req <= 1'b0;
                            end
                        end else begin
                            r_frm <= r_frm + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= c_st_idle;
                    r_stop_req <= 1'b0;
                end
            endcase
        end
    end

    assign led      = r_led;
    assign duty     = r_duty;
    assign state    = r_state;
    assign busy     = (r_state != c_st_idle);
    assign frame_tc = w_frame_tc;

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_fade_ctrl
// Brief    : Scoreboard bench for pwm_fade_ctrl (20-clk frames)
// Revision : 1.0
// ============================================================================
module tb_pwm_fade_ctrl;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_UP   = 3'd1;
    localparam logic [2:0] ST_HH   = 3'd2;
    localparam logic [2:0] ST_DN   = 3'd3;
    localparam logic [2:0] ST_HL   = 3'd4;

    logic       clk = 1'b0;
    logic       rst, start, stop, loop;
    logic [3:0] max_duty;
    logic       led, busy, frame_tc;
    logic [3:0] duty;
    logic [2:0] state;

    int         checks = 0;
    int         errors = 0;
    logic [6:0] exp_q[$];
    int         dt_q[$];
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;

    pwm_fade_ctrl #(
        .CLK_DIV(1), .PWM_TOP(9), .STEP_FRAMES(2), .HOLD_FRAMES(3), .LED_ON(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
        .max_duty(max_duty), .led(led), .duty(duty), .busy(busy),
        .frame_tc(frame_tc), .state(state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Expected {state,duty} change, and clk distance from the previous change (0 = phase-dependent).
    task automatic expect_sd(input logic [2:0] st, input logic [3:0] du, input int dt);
        exp_q.push_back({st, du});
        dt_q.push_back(dt);
    endtask

    task automatic monitor();
        logic [6:0] prev, cur, e;
        int cyc, last, d;
        cyc = 0; last = 0; prev = 'x;
        forever begin
            @(negedge clk);
            cyc++;
            cur = {state, duty};
            if (mon_en && (cur !== prev)) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_change: got state %0d duty %0d expected no change", cur[6:4], cur[3:0]);
                end else begin
                    e = exp_q.pop_front();
                    d = dt_q.pop_front();
                    check("seq_state_duty", 32'(cur), 32'(e));
                    if (d != 0) check("seq_delta_clk", 32'(cyc - last), 32'(d));
                end
                last = cyc;
            end
            prev = cur;
        end
    endtask

    task automatic wait_sd(input logic [2:0] st, input logic [3:0] du, input bit any_duty,
                           input int budget, input string name);
        int n;
        n = 0;
        while (!((state == st) && (any_duty || duty == du)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL timeout_%s: got state %0d duty %0d expected state %0d", name, state, duty, st);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_%s: got %0d pending expected 0", name, exp_q.size());
            exp_q.delete();
            dt_q.delete();
        end
    endtask

    task automatic clks_to_tc(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tc && n < 40);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        int n, zeros, ons;
        logic first_led, second_led;
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; max_duty = 4'd0;
        fork
            monitor();
        join_none

        // Reset and frame cadence
        repeat (3) @(negedge clk);
        check("rst_led", 32'(led), 32'd1);
        check("rst_duty", 32'(duty), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state), 32'(ST_IDLE));
        rst = 1'b0;
        clks_to_tc(n); check("first_frame_tc", 32'(n), 32'd19);
        clks_to_tc(n); check("frame_tc_period1", 32'(n), 32'd20);
        clks_to_tc(n); check("frame_tc_period2", 32'(n), 32'd20);
        mon_en = 1'b1;

        // Single ramp to 4, with a duty-cycle check during HOLD_HI
        max_duty = 4'd4;
        expect_sd(ST_UP, 0, 0);  expect_sd(ST_UP, 1, 0);  expect_sd(ST_UP, 2, 40);
        expect_sd(ST_UP, 3, 40); expect_sd(ST_HH, 4, 40); expect_sd(ST_DN, 4, 60);
        expect_sd(ST_DN, 3, 40); expect_sd(ST_DN, 2, 40); expect_sd(ST_DN, 1, 40);
        expect_sd(ST_IDLE, 0, 40);
        pulse_start();
        repeat (5) @(negedge clk);
        check("busy_in_up", 32'(busy), 32'd1);
        pulse_start();
        wait_sd(ST_HH, 4, 1'b0, 300, "hold_hi4");
        clks_to_tc(n);
        zeros = 0; first_led = 1'b0; second_led = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) first_led = led;
            if (k == 2) second_led = led;
            if (led == 1'b0) zeros++;
        end
        check("duty4_led_slot9", 32'(first_led), 32'd1);
        check("duty4_led_slot0", 32'(second_led), 32'd0);
        check("duty4_low_clks", 32'(zeros), 32'd8);
        wait_drain(600, "ramp4");
        @(negedge clk);
        check("busy_end_ramp4", 32'(busy), 32'd0);

        // Clamp 15 -> 10, led fully on in HOLD_HI
        max_duty = 4'd15;
        expect_sd(ST_UP, 0, 0); expect_sd(ST_UP, 1, 0);
        for (int d = 2; d <= 9; d++) expect_sd(ST_UP, 4'(d), 40);
        expect_sd(ST_HH, 10, 40); expect_sd(ST_DN, 10, 60);
        for (int d = 9; d >= 1; d--) expect_sd(ST_DN, 4'(d), 40);
        expect_sd(ST_IDLE, 0, 40);
        pulse_start();
        wait_sd(ST_HH, 10, 1'b0, 600, "hold_hi10");
        @(negedge clk);
        ons = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (led == 1'b0) ons++;
        end
        check("duty10_on_clks", 32'(ons), 32'd40);
        wait_drain(900, "ramp10");
        max_duty = 4'd0;
        pulse_start();
        repeat (50) @(negedge clk);
        check("zero_target_state", 32'(state), 32'(ST_IDLE));
        check("zero_target_busy", 32'(busy), 32'd0);

        // Looping, target changed to 5 during DOWN
        loop = 1'b1; max_duty = 4'd3;
        expect_sd(ST_UP, 0, 0);  expect_sd(ST_UP, 1, 0);  expect_sd(ST_UP, 2, 40);
        expect_sd(ST_HH, 3, 40); expect_sd(ST_DN, 3, 60); expect_sd(ST_DN, 2, 40);
        expect_sd(ST_DN, 1, 40); expect_sd(ST_HL, 0, 40); expect_sd(ST_UP, 0, 60);
        for (int d = 1; d <= 4; d++) expect_sd(ST_UP, 4'(d), 40);
        expect_sd(ST_HH, 5, 40); expect_sd(ST_DN, 5, 60);
        for (int d = 4; d >= 1; d--) expect_sd(ST_DN, 4'(d), 40);
        expect_sd(ST_IDLE, 0, 40);
        pulse_start();
        wait_sd(ST_DN, 0, 1'b1, 400, "loop_down");
        max_duty = 4'd5;
        wait_sd(ST_HH, 5, 1'b0, 800, "loop_hold5");
        loop = 1'b0;
        wait_drain(800, "loop");

        // Stop during UP at duty 2
        max_duty = 4'd5;
        expect_sd(ST_UP, 0, 0);  expect_sd(ST_UP, 1, 0);  expect_sd(ST_UP, 2, 40);
        expect_sd(ST_DN, 2, 20); expect_sd(ST_DN, 1, 40); expect_sd(ST_IDLE, 0, 40);
        pulse_start();
        wait_sd(ST_UP, 2, 1'b0, 200, "up2");
        pulse_stop();
        wait_drain(300, "stop");
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        repeat (50) @(negedge clk);
        check("start_stop_state", 32'(state), 32'(ST_IDLE));
        check("start_stop_busy", 32'(busy), 32'd0);

        // Reset mid-sequence
        max_duty = 4'd3;
        expect_sd(ST_UP, 0, 0); expect_sd(ST_IDLE, 0, 0);
        pulse_start();
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_led", 32'(led), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_duty", 32'(duty), 32'd0);
        wait_drain(10, "midrst");
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
